// File: rtl/gobou_net_reader.sv
// Streaming reader for the gobou weight RAM: converts (base, count) into sequential reads
// and hides the RAM's one-cycle latency behind a 2-entry, credit-issued output FIFO.
module gobou_net_reader #(
    parameter int DWIDTH  = 16,
    parameter int NETSIZE = 14
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [NETSIZE-1:0]        base_addr,
    input  logic [NETSIZE:0]          count,
    output logic                      busy,
    output logic                      done,
    output logic [NETSIZE-1:0]        mem_addr,
    input  logic signed [DWIDTH-1:0]  read_data,
    output logic signed [DWIDTH-1:0]  out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_last
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                    state_q, state_d;
    logic [NETSIZE-1:0]        addr_q, addr_d;
    logic [NETSIZE:0]          iss_rem_q, iss_rem_d;
    logic [NETSIZE:0]          pop_rem_q, pop_rem_d;
    logic                      inflight_q, infl_last_q;
    logic [1:0][DWIDTH-1:0]    fifo_data_q;
    logic [1:0]                fifo_last_q;
    logic                      wr_q, rd_q;
    logic [1:0]                occ_q;

    logic       pop, issue, done_w;
    logic [2:0] used;

    // Credits in use: buffered words plus the read still in flight, minus the word leaving now.
    assign pop    = (occ_q != 2'd0) && out_ready;
    assign used   = {1'b0, occ_q} + {2'b0, inflight_q} - {2'b0, pop};
    assign issue  = (state_q == RUN) && (iss_rem_q != '0) && (used < 3'd2);
    assign done_w = (state_q == DRAIN) && (occ_q == 2'd0) && !inflight_q && (pop_rem_q == '0);

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        iss_rem_d = iss_rem_q;
        pop_rem_d = pop ? pop_rem_q - (NETSIZE+1)'(1) : pop_rem_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    iss_rem_d = count;
                    pop_rem_d = count;
                    if (count != '0) begin
                        state_d = RUN;
                        addr_d  = base_addr;
                    end else begin
                        state_d = DRAIN;
                    end
                end
            end
            RUN: begin
                if (issue) begin
                    addr_d    = addr_q + NETSIZE'(1);
                    iss_rem_d = iss_rem_q - (NETSIZE+1)'(1);
                    if (iss_rem_q == (NETSIZE+1)'(1)) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (done_w) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            iss_rem_q <= '0;
            pop_rem_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            iss_rem_q <= iss_rem_d;
            pop_rem_q <= pop_rem_d;
        end
    end

    // read_data lands one cycle after the issue, so the push is simply the delayed issue.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_q  <= 1'b0;
            infl_last_q <= 1'b0;
            fifo_data_q <= '0;
            fifo_last_q <= '0;
            wr_q        <= 1'b0;
            rd_q        <= 1'b0;
            occ_q       <= 2'd0;
        end else begin
            inflight_q  <= issue;
            infl_last_q <= issue && (iss_rem_q == (NETSIZE+1)'(1));
            if (inflight_q) begin
                fifo_data_q[wr_q] <= read_data;
                fifo_last_q[wr_q] <= infl_last_q;
                wr_q              <= ~wr_q;
            end
            if (pop) rd_q <= ~rd_q;
            case ({inflight_q, pop})
                2'b10:   occ_q <= occ_q + 2'd1;
                2'b01:   occ_q <= occ_q - 2'd1;
                default: occ_q <= occ_q;
            endcase
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = done_w;
    assign mem_addr  = addr_q;
    assign out_valid = (occ_q != 2'd0);
    assign out_data  = out_valid ? fifo_data_q[rd_q] : '0;
    assign out_last  = out_valid && fifo_last_q[rd_q];

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(inflight_q && !pop && (occ_q == 2'd2)));

endmodule

// File: tb/tb_gobou_net_reader.sv
// Scoreboard bench for gobou_net_reader on a 16-word RAM model (mem[i] = i + 100).
module tb_gobou_net_reader;
    localparam int DW    = 16;
    localparam int NS    = 4;
    localparam int DEPTH = 16;

    logic                 clk = 1'b0;
    logic                 rst, start, out_ready;
    logic [NS-1:0]        base_addr, mem_addr;
    logic [NS:0]          count;
    logic                 busy, done, out_valid, out_last;
    logic signed [DW-1:0] read_data, out_data;
    logic signed [DW-1:0] mem [DEPTH];

    typedef struct packed { logic [DW-1:0] data; logic last; } exp_t;
    exp_t sb[$];
    int vecs = 0;
    int errs = 0;

    gobou_net_reader #(.DWIDTH(DW), .NETSIZE(NS)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .count(count),
        .busy(busy), .done(done), .mem_addr(mem_addr), .read_data(read_data),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) read_data <= mem[mem_addr];

    // Drive a request and queue the words it should produce.
    task automatic req(input logic [NS-1:0] b, input logic [NS:0] n);
        start = 1'b1; base_addr = b; count = n;
        for (int i = 0; i < int'(n); i++)
            sb.push_back('{data: mem[(int'(b) + i) % DEPTH], last: (i == int'(n) - 1)});
    endtask

    task automatic idle_gap();
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; out_ready = 1'b0; base_addr = '0; count = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vecs++; if (busy !== 1'b0)      begin errs++; $display("FAIL reset_busy got %b want 0", busy); end
        vecs++; if (done !== 1'b0)      begin errs++; $display("FAIL reset_done got %b want 0", done); end
        vecs++; if (mem_addr !== '0)    begin errs++; $display("FAIL reset_addr got %0d want 0", mem_addr); end
        vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL reset_valid got %b want 0", out_valid); end
        vecs++; if (out_last !== 1'b0)  begin errs++; $display("FAIL reset_last got %b want 0", out_last); end
        vecs++; if (out_data !== '0)    begin errs++; $display("FAIL reset_data got %0d want 0", out_data); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        exp_t e;
        out_ready = 1'b1;
        req(4'd5, 5'd4);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            vecs++; if (busy !== (c >= 1 && c <= 7))
                begin errs++; $display("FAIL basic_busy c=%0d got %b want %b", c, busy, (c >= 1 && c <= 7)); end
            vecs++; if (done !== (c == 7))
                begin errs++; $display("FAIL basic_done c=%0d got %b want %b", c, done, (c == 7)); end
            vecs++; if (out_valid !== (c >= 3 && c <= 6))
                begin errs++; $display("FAIL basic_valid c=%0d got %b want %b", c, out_valid, (c >= 3 && c <= 6)); end
            if (c == 1) begin
                vecs++; if (mem_addr !== 4'd5) begin errs++; $display("FAIL basic_addr got %0d want 5", mem_addr); end
            end
            if (out_valid && out_ready && sb.size() > 0) begin
                e = sb.pop_front();
                vecs++; if ({out_data, out_last} !== {e.data, e.last})
                    begin errs++; $display("FAIL basic_word c=%0d got %0d/%b want %0d/%b", c, out_data, out_last, e.data, e.last); end
            end
            @(posedge clk); #1;
            start = 1'b0;
        end
        vecs++; if (sb.size() != 0) begin errs++; $display("FAIL basic_left got %0d want 0", sb.size()); sb.delete(); end
        idle_gap();
    endtask

    task automatic test_backpressure();
        exp_t e;
        logic [5:0] pat;
        logic held;
        logic [DW-1:0] held_data;
        int hs, dones;
        pat = 6'b101001;  // bit c%6: 1,0,0,1,0,1
        held = 1'b0; held_data = '0; hs = 0; dones = 0;
        out_ready = pat[0];
        req(4'd5, 5'd4);
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (held) begin
                vecs++; if (out_valid !== 1'b1 || out_data !== held_data)
                    begin errs++; $display("FAIL bp_stall c=%0d got %b/%0d want 1/%0d", c, out_valid, out_data, held_data); end
            end
            if (out_valid && out_ready) begin
                hs++;
                if (sb.size() == 0) begin
                    vecs++; errs++; $display("FAIL bp_extra c=%0d got %0d want none", c, out_data);
                end else begin
                    e = sb.pop_front();
                    vecs++; if ({out_data, out_last} !== {e.data, e.last})
                        begin errs++; $display("FAIL bp_word c=%0d got %0d/%b want %0d/%b", c, out_data, out_last, e.data, e.last); end
                end
            end
            if (done) begin
                dones++;
                vecs++; if (hs != 4) begin errs++; $display("FAIL bp_done_hs got %0d want 4", hs); end
            end
            held = out_valid && !out_ready;
            held_data = out_data;
            @(posedge clk); #1;
            start = 1'b0;
            out_ready = pat[(c + 1) % 6];
        end
        vecs++; if (dones != 1) begin errs++; $display("FAIL bp_done_count got %0d want 1", dones); end
        vecs++; if (sb.size() != 0) begin errs++; $display("FAIL bp_left got %0d want 0", sb.size()); sb.delete(); end
        out_ready = 1'b1;
        idle_gap();
    endtask

    task automatic test_wrap();
        exp_t e;
        logic [NS-1:0] ea;
        int dones;
        dones = 0;
        out_ready = 1'b1;
        req(4'd14, 5'd4);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c >= 1 && c <= 4) begin
                ea = NS'((14 + c - 1) % DEPTH);
                vecs++; if (mem_addr !== ea) begin errs++; $display("FAIL wrap_addr c=%0d got %0d want %0d", c, mem_addr, ea); end
            end
            if (out_valid && out_ready && sb.size() > 0) begin
                e = sb.pop_front();
                vecs++; if ({out_data, out_last} !== {e.data, e.last})
                    begin errs++; $display("FAIL wrap_word c=%0d got %0d/%b want %0d/%b", c, out_data, out_last, e.data, e.last); end
            end
            if (done) dones++;
            @(posedge clk); #1;
            start = 1'b0;
        end
        vecs++; if (dones != 1 || sb.size() != 0)
            begin errs++; $display("FAIL wrap_end got done=%0d left=%0d want 1/0", dones, sb.size()); sb.delete(); end
        idle_gap();
    endtask

    task automatic test_full_depth();
        exp_t e;
        int hs, dones;
        hs = 0; dones = 0;
        out_ready = 1'b1;
        req(4'd3, 5'd16);
        for (int c = 0; c < 120; c++) begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                hs++;
                if (sb.size() == 0) begin
                    vecs++; errs++; $display("FAIL full_extra c=%0d got %0d want none", c, out_data);
                end else begin
                    e = sb.pop_front();
                    vecs++; if ({out_data, out_last} !== {e.data, e.last})
                        begin errs++; $display("FAIL full_word c=%0d got %0d/%b want %0d/%b", c, out_data, out_last, e.data, e.last); end
                end
            end
            if (done) begin
                dones++;
                vecs++; if (hs != 16) begin errs++; $display("FAIL full_done_hs got %0d want 16", hs); end
            end
            @(posedge clk); #1;
            start = 1'b0;
            out_ready = ($urandom_range(0, 3) != 0);
        end
        vecs++; if (dones != 1) begin errs++; $display("FAIL full_done_count got %0d want 1", dones); end
        vecs++; if (sb.size() != 0) begin errs++; $display("FAIL full_left got %0d want 0", sb.size()); sb.delete(); end
        out_ready = 1'b1;
        idle_gap();
    endtask

    task automatic test_zero_count();
        out_ready = 1'b1;
        req(4'd7, 5'd0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            vecs++; if (busy !== (c == 1)) begin errs++; $display("FAIL zero_busy c=%0d got %b want %b", c, busy, (c == 1)); end
            vecs++; if (done !== (c == 1)) begin errs++; $display("FAIL zero_done c=%0d got %b want %b", c, done, (c == 1)); end
            vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL zero_valid c=%0d got %b want 0", c, out_valid); end
            @(posedge clk); #1;
            start = 1'b0;
        end
        idle_gap();
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int dones;
        out_ready = 1'b1;
        req(4'd2, 5'd10);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (c < 5 && out_valid && out_ready && sb.size() > 0) begin
                e = sb.pop_front();
                vecs++; if ({out_data, out_last} !== {e.data, e.last})
                    begin errs++; $display("FAIL rstmid_word c=%0d got %0d/%b want %0d/%b", c, out_data, out_last, e.data, e.last); end
            end
            if (c == 6) begin
                vecs++; if ({out_valid, busy, mem_addr} !== {1'b0, 1'b0, 4'd0})
                    begin errs++; $display("FAIL rstmid_after got v=%b b=%b a=%0d want 0/0/0", out_valid, busy, mem_addr); end
            end
            if (c > 6) begin
                vecs++; if (done !== 1'b0 || out_valid !== 1'b0)
                    begin errs++; $display("FAIL rstmid_quiet c=%0d got d=%b v=%b want 0/0", c, done, out_valid); end
            end
            @(posedge clk); #1;
            start = 1'b0;
            rst = (c == 4);
        end
        sb.delete();
        dones = 0;
        req(4'd9, 5'd2);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (out_valid && out_ready && sb.size() > 0) begin
                e = sb.pop_front();
                vecs++; if ({out_data, out_last} !== {e.data, e.last})
                    begin errs++; $display("FAIL rstmid_new c=%0d got %0d/%b want %0d/%b", c, out_data, out_last, e.data, e.last); end
            end
            if (done) begin
                dones++;
                vecs++; if (c != 5) begin errs++; $display("FAIL rstmid_new_done got cycle %0d want 5", c); end
            end
            @(posedge clk); #1;
            start = 1'b0;
        end
        vecs++; if (dones != 1 || sb.size() != 0)
            begin errs++; $display("FAIL rstmid_new_end got done=%0d left=%0d want 1/0", dones, sb.size()); sb.delete(); end
        idle_gap();
    endtask

    task automatic test_start_busy();
        exp_t e;
        int dones;
        logic saw8;
        dones = 0; saw8 = 1'b0;
        out_ready = 1'b1;
        req(4'd0, 5'd5);
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            vecs++; if (busy !== (c >= 1 && c <= 8))
                begin errs++; $display("FAIL sb_busy c=%0d got %b want %b", c, busy, (c >= 1 && c <= 8)); end
            if (mem_addr == 4'd8) saw8 = 1'b1;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    vecs++; errs++; $display("FAIL sb_extra c=%0d got %0d want none", c, out_data);
                end else begin
                    e = sb.pop_front();
                    vecs++; if ({out_data, out_last} !== {e.data, e.last})
                        begin errs++; $display("FAIL sb_word c=%0d got %0d/%b want %0d/%b", c, out_data, out_last, e.data, e.last); end
                end
            end
            if (done) dones++;
            @(posedge clk); #1;
            start = (c == 1);
            if (c == 1) begin base_addr = 4'd8; count = 5'd3; end
        end
        vecs++; if (dones != 1 || sb.size() != 0 || saw8)
            begin errs++; $display("FAIL sb_end got done=%0d left=%0d saw8=%b want 1/0/0", dones, sb.size(), saw8); sb.delete(); end
        idle_gap();
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i + 100);
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap();
        test_full_depth();
        test_zero_count();
        test_reset_mid();
        test_start_busy();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/gobou_net_reader.md
# gobou_net_reader

Streaming read front-end for the gobou network-weight RAM. It turns a (base, count) request into sequential reads of the weight memory. It absorbs the RAM's one-cycle registered-address read latency and delivers words to the downstream MAC array over a valid/ready stream with full backpressure. A 2-entry output buffer with credit-based issue sustains one word per cycle when the consumer is always ready.

## Interface
Parameters:
- DWIDTH, 16, weight word width (signed)
- NETSIZE, 14, weight-RAM address width; depth 2^NETSIZE

Ports:
- clk  in  1  single clock, all logic on posedge
- rst  in  1  reset, synchronous, active-high
- start  in  1  request pulse; sampled only in IDLE
- base_addr  in  NETSIZE  first word address, captured on accepted start
- count  in  NETSIZE+1  words to read, 0..2^NETSIZE, captured on accepted start
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse, request complete
- mem_addr  out  NETSIZE  address to weight RAM; RAM registers it every cycle
- read_data  in  DWIDTH  RAM output; equals mem[mem_addr of previous cycle]
- out_data  out  DWIDTH  stream word (signed)
- out_valid  out  1  stream valid
- out_ready  in  1  stream ready from consumer
- out_last  out  1  high with the final word of the request

## Operation
- States are IDLE, RUN and DRAIN.
- **IDLE:**
  - start=1 with count>0 captures base_addr and count and moves to RUN.
  - start=1 with count=0 moves to DRAIN with nothing issued, so done pulses the next cycle.
- **RUN:**
  - An issue occurs in a cycle when remaining-to-issue > 0 and (occ + inflight − pop) < 2.
  - occ is the number of buffer entries, 0..2. inflight=1 if an issue happened last cycle. pop = out_valid & out_ready.
  - On issue, mem_addr = next address. The next address then increments modulo 2^NETSIZE, wrapping from 2^NETSIZE−1 to 0.
  - When no issue occurs, mem_addr holds its value. This is harmless because the RAM is read-only from this block.
  - When the last word is issued, the state moves to DRAIN.
- **DRAIN:**
  - No issues.
  - When occ=0, inflight=0 and all count words have been popped, assert done for 1 cycle, then go to IDLE.
- **Buffer:**
  - A 2-entry FIFO. read_data is written in the cycle after an issue.
  - A push and a pop in the same cycle are both honoured.
  - Overflow is impossible by the issue rule. Any overflow condition is an assertion failure.
- **Output:**
  - out_data/out_valid present the FIFO head.
  - out_data must remain stable while out_valid=1 and out_ready=0.
  - out_last=1 when the head entry is word count−1 of the request.
- start while busy is ignored; no queueing.
- rst in any state:
  - state=IDLE; FIFO emptied; inflight cleared; counters cleared.
  - A burst interrupted by rst produces no further words and no done.
- **Reset values:** busy=0, done=0, mem_addr=0, out_valid=0, out_last=0, out_data=0.

## Timing
- The following latency chain assumes out_ready=1 throughout:
  - start is sampled high at the end of cycle 0.
  - Cycle 1: busy=1 and mem_addr=base.
  - Cycle 2: read_data=mem[base], pushed into the FIFO.
  - Cycle 3: out_valid=1 and out_data=mem[base].
- Throughput is 1 word/cycle with out_ready held high.
  - N words occupy out_valid for cycles 3..N+2.
  - done pulses in cycle N+3; busy falls in the same cycle as done.
- Under backpressure, at most 2 words are buffered. Issue resumes in the same cycle as the pop that frees a credit.
- count=0: start at cycle 0 gives busy=1 and done=1 in cycle 1; IDLE in cycle 2; out_valid never asserted.
- done and an accepted start can never coincide, because start is sampled only in IDLE.

## Test plan
- **Basic burst:** RAM preloaded mem[i]=i+100; base=5, count=4, out_ready=1.
  - Required: out_data 105,106,107,108 in cycles 3–6, with out_last only on 108.
  - done in cycle 7.
- **Backpressure:** same load; out_ready toggles 1,0,0,1,0,1…
  - Required: words are delivered in order with no loss or duplication.
  - out_data is stable while stalled; occ never exceeds 2; done fires after the 4th handshake.
- **Wrap:** NETSIZE=4, base=14, count=4.
  - Required: mem_addr sequence 14,15,0,1; data mem[14],mem[15],mem[0],mem[1].
- **Full depth and zero count:**
  - count=2^NETSIZE: exactly 2^NETSIZE words, last one flagged.
  - count=0: done one cycle after start, no out_valid.
- **Reset mid-burst:** rst asserted at the 3rd word of a count=10 burst.
  - Required: next cycle out_valid=0, busy=0, mem_addr=0, and no done.
  - A new start after reset runs cleanly.
- **Start while busy:** a second start with a different base during a burst is ignored.
  - Required: the original stream completes unchanged; busy drops only at its done.
